// File: rtl/mmix_bus_arbiter.sv
// Two-port arbiter onto a single MMIX memory bus: port 0 (CPU), port 1 (debug/DMA).
// Latency: request sampled at edge E drives the bus after E. The earliest pN_done is the cycle after E+1.
// Backpressure: requesters hold strobes until pN_done; the bus is held in BUSY until mmix_done.
// Build option: define MMIX_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to port 0.
module mmix_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [ADDR_W-1:0] p0_address,
    input  logic [1:0]        p0_datasize,
    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [DATA_W-1:0] p0_writedata,
    output logic [DATA_W-1:0] p0_readdata,
    output logic              p0_done,

    input  logic [ADDR_W-1:0] p1_address,
    input  logic [1:0]        p1_datasize,
    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [DATA_W-1:0] p1_writedata,
    output logic [DATA_W-1:0] p1_readdata,
    output logic              p1_done,

    output logic [ADDR_W-1:0] mmix_address,
    output logic [1:0]        mmix_datasize,
    output logic              mmix_read,
    output logic              mmix_write,
    output logic [DATA_W-1:0] mmix_writedata,
    input  logic [DATA_W-1:0] mmix_readdata,
    input  logic              mmix_done,

    output logic              arb_grant,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              req0;
    logic              req1;
    logic              any_req;
    logic              grant_nxt;
    logic              launch;
    logic              finish;

    logic [ADDR_W-1:0] sel_address;
    logic [1:0]        sel_datasize;
    logic [DATA_W-1:0] sel_writedata;
    logic              sel_is_read;

    logic [DATA_W-1:0] rd_cap;

    assign req0    = p0_read | p0_write;
    assign req1    = p1_read | p1_write;
    assign any_req = req0 | req1;

    // Requests are only looked at in IDLE; a returning mmix_done only matters in BUSY.
    assign launch  = (state == IDLE) && any_req;
    assign finish  = (state == BUSY) && mmix_done;

`ifdef MMIX_ARB_ROUND_ROBIN_EN
    // Port granted by the previous transaction; resets to 1 so port 0 wins the first contention.
    logic last_grant;

    // Remember who got the bus so the other port wins the next tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (launch) begin
            last_grant <= grant_nxt;
        end
    end

    // Tie goes to the port not granted last; a lone request always wins.
    always_comb begin
        grant_nxt = 1'b0;
        if (req0 && req1) begin
            grant_nxt = ~last_grant;
        end else begin
            grant_nxt = ~req0;
        end
    end
`else
    // Fixed priority: port 0 whenever it requests.
    always_comb begin
        grant_nxt = 1'b0;
        if (!req0) begin
            grant_nxt = 1'b1;
        end
    end
`endif

    // Mux the winning port's request fields; read beats write when both strobes are up.
    always_comb begin
        sel_address   = p0_address;
        sel_datasize  = p0_datasize;
        sel_writedata = p0_writedata;
        sel_is_read   = p0_read;
        if (grant_nxt) begin
            sel_address   = p1_address;
            sel_datasize  = p1_datasize;
            sel_writedata = p1_writedata;
            sel_is_read   = p1_read;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: BUSY has no timeout and waits for mmix_done indefinitely.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)   state_nxt = BUSY;
            BUSY:    if (mmix_done) state_nxt = ACK;
            ACK:                    state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Bus request registers: loaded at launch, strobes dropped when the memory answers.
    // The request fields stay frozen through BUSY because only launch can load them.
    // Reset clears the strobes asynchronously, abandoning any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mmix_address   <= '0;
            mmix_datasize  <= 2'd0;
            mmix_writedata <= '0;
            mmix_read      <= 1'b0;
            mmix_write     <= 1'b0;
            arb_grant      <= 1'b0;
        end else if (launch) begin
            mmix_address   <= sel_address;
            mmix_datasize  <= sel_datasize;
            mmix_writedata <= sel_writedata;
            mmix_read      <= sel_is_read;
            mmix_write     <= ~sel_is_read;
            arb_grant      <= grant_nxt;
        end else if (finish) begin
            mmix_read      <= 1'b0;
            mmix_write     <= 1'b0;
        end
    end

    // Capture the memory response on completion; it is held until the next completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cap <= '0;
        end else if (finish) begin
            rd_cap <= mmix_readdata;
        end
    end

    // Both ports see the capture register; only the granted one gets a done pulse in ACK.
    assign p0_readdata = rd_cap;
    assign p1_readdata = rd_cap;
    assign p0_done     = (state == ACK) && !arb_grant;
    assign p1_done     = (state == ACK) &&  arb_grant;
    assign arb_busy    = (state == BUSY);

endmodule

// File: doc/mmix_bus_arbiter.md
MMIX_BUS_ARBITER -- requirements
Module: mmix_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, the address width of every port.
REQ-002 The block SHALL have parameter DATA_W, default 64, the read/write data width of every port.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 pN_address  in  ADDR_W  request address, for N in {0,1}; port 0 is the CPU, port 1 is the debug/DMA master.
REQ-006 pN_datasize  in  2  access size: 0 byte, 1 wyde, 2 tetra, 3 octa.
REQ-007 pN_read / pN_write  in  1 each  request strobes, held high until pN_done.
REQ-008 pN_writedata  in  DATA_W  write data.
REQ-009 pN_readdata  out  DATA_W  read data; valid while pN_done is high.
REQ-010 pN_done  out  1  one-cycle completion pulse.
REQ-011 mmix_address / mmix_datasize / mmix_read / mmix_write / mmix_writedata  out  ADDR_W/2/1/1/DATA_W  shared memory bus.
REQ-012 mmix_readdata  in  DATA_W ; mmix_done  in  1  memory response, where mmix_done is a one-cycle pulse.
REQ-013 arb_grant  out  1  owner of the current or most recent transaction; arb_busy  out  1  high in BUSY.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and ACK.
REQ-015 In IDLE, a port requests when pN_read|pN_write; on the edge where any request is sampled, the block SHALL grant one port, latch its address, size, writedata and op, and go to BUSY.
REQ-016 mmix_read or mmix_write SHALL be registered and high from the first BUSY cycle, with all mmix_* outputs stable throughout BUSY.
REQ-017 If pN_read and pN_write are both high, the block SHALL treat the request as a read and ignore the write.
REQ-018 In BUSY, on the edge where mmix_done=1 is sampled, the block SHALL capture mmix_readdata, drop mmix_read/mmix_write and go to ACK.
REQ-019 In ACK, the granted port's pN_done SHALL be high for exactly one cycle and its pN_readdata SHALL equal the captured data; the FSM SHALL then return to IDLE.
REQ-020 The ungranted port's pN_done SHALL stay 0; its pN_readdata SHALL be driven from the same capture register (a don't-care for it).
REQ-021 Requests SHALL NOT be sampled in BUSY or ACK; requesters drop strobes on the edge sampling pN_done, so no duplicate issue occurs.
REQ-022 Minimum request-to-done latency: request sampled at edge E, mmix_read high after E, mmix_done sampled at E+1 at the earliest, pN_done high after E+1.
REQ-023 The block SHALL NOT time out: BUSY waits indefinitely for mmix_done.
REQ-024 mmix_done received while not in BUSY SHALL be ignored.
REQ-025 A request strobe that falls in BUSY SHALL NOT abort the transaction in flight.

Reset
REQ-026 While reset_n=0, the block SHALL be in IDLE with every output 0 and the capture register 0.
REQ-027 The last-grant register SHALL reset to 1, so that port 0 wins the first contention.
REQ-028 Reset asserted in BUSY or ACK SHALL abandon the transaction immediately: mmix_read and mmix_write go low asynchronously and no pN_done is generated.

Configuration
REQ-029 With macro MMIX_ARB_ROUND_ROBIN_EN defined, simultaneous requests in IDLE SHALL be granted to the port not granted last; a lone request is always granted.
REQ-030 Without MMIX_ARB_ROUND_ROBIN_EN, port 0 SHALL always win contention (fixed priority), and the last-grant register SHALL be omitted.

Verification
REQ-031 Port 0 read: addr 0x58, size 3, memory returns 0x0123456789ABCDEF with mmix_done 2 cycles after mmix_read -> p0_done one cycle with p0_readdata=0x0123456789ABCDEF, arb_grant=0.
REQ-032 Port 1 write: addr 0x1000, size 2, data 0xDEADBEEF -> mmix_write=1, mmix_address=0x1000, mmix_datasize=2, mmix_writedata=0xDEADBEEF until mmix_done; p1_done one pulse; p0_done stays 0.
REQ-033 Both ports request reads continuously for 4 transactions -> with the macro, grant order 0,1,0,1; without it, 0,0,0,0 while p0 keeps requesting.
REQ-034 reset_n pulled low for one cycle during BUSY with mmix_done pending -> mmix_read drops immediately, no pN_done appears, and a later mmix_done is ignored.
REQ-035 Minimum latency with mmix_done returned in the first BUSY cycle -> exactly one BUSY cycle, then pN_done in the next cycle, then IDLE.
REQ-036 p0_read and p0_write high together at addr 0x20 -> a read is issued (mmix_write stays 0).
